// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite burst master: one command at a time, SINGLE/INCRx/WRAPx, one-entry write staging.
// Optional feature: define AHBM_WRAP_EN for true wrapping WRAPx; otherwise WRAPx runs as linear INCRx.
module ahb_lite_burst_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic [1:0]        HTRANS,
   output logic              HMASTLOCK,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [2:0]        cmd_burst,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              rdata_last,
   output logic              done,
   output logic              err
);
   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;
   localparam logic [2:0] MAX_SIZE  = (DATA_W == 64) ? 3'd3 : 3'd2;

   typedef enum logic [2:0] {IDLE, NSEQ, SEQ, LAST_DATA, ERR} state_t;
   state_t state_reg;

   logic [ADDR_W-1:0] haddr_reg;
   logic [1:0]        htrans_reg;
   logic              hwrite_reg;
   logic [2:0]        hsize_reg;
   logic [2:0]        hburst_reg;
   logic [DATA_W-1:0] hwdata_reg;
   logic [3:0]        beat_reg;
   logic [3:0]        last_reg;
   logic              wrap_reg;
   logic              dp_valid_reg;
   logic              dp_write_reg;
   logic              dp_last_reg;
   logic              stg_full_reg;
   logic [DATA_W-1:0] stg_data_reg;
   logic              done_reg;
   logic              err_reg;

   logic              addr_done, consume, accept_w, stg_full_next, rd_fire, dp_err;
   logic [ADDR_W-1:0] incr_addr, wrap_mask, next_addr;
   logic [3:0]        cmd_last;
   logic [2:0]        cmd_hburst;
   logic              cmd_wrap;

   always_comb begin
      cmd_last   = 4'd0;
      cmd_hburst = 3'b000;
      cmd_wrap   = 1'b0;
      case (cmd_burst)
         3'b010, 3'b011: cmd_last = 4'd3;
         3'b100, 3'b101: cmd_last = 4'd7;
         3'b110, 3'b111: cmd_last = 4'd15;
         default:        cmd_last = 4'd0;
      endcase
      // INCR (001) falls through as SINGLE
      if (cmd_burst[2:1] != 2'b00) begin
`ifdef AHBM_WRAP_EN
         cmd_hburst = cmd_burst;
         cmd_wrap   = ~cmd_burst[0];
`else
         cmd_hburst = cmd_burst | 3'b001;
`endif
      end
   end

   assign incr_addr = haddr_reg + (ADDR_W'(1) << hsize_reg);
   assign wrap_mask = (ADDR_W'({1'b0, last_reg} + 5'd1) << hsize_reg) - ADDR_W'(1);
   assign next_addr = wrap_reg ? ((haddr_reg & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;

   assign addr_done     = HREADY && htrans_reg[1];
   assign consume       = addr_done && hwrite_reg;
   assign wdata_ready   = !stg_full_reg || consume;
   assign accept_w      = wdata_valid && wdata_ready;
   assign stg_full_next = accept_w || (stg_full_reg && !consume);
   assign dp_err        = dp_valid_reg && HRESP;
   assign rd_fire       = dp_valid_reg && !dp_write_reg && HREADY && !HRESP;

   assign cmd_ready   = (state_reg == IDLE);
   assign HADDR       = haddr_reg;
   assign HWRITE      = hwrite_reg;
   assign HSIZE       = hsize_reg;
   assign HBURST      = hburst_reg;
   assign HTRANS      = htrans_reg;
   assign HWDATA      = hwdata_reg;
   assign HPROT       = 4'b0011;
   assign HMASTLOCK   = 1'b0;
   assign rdata       = rd_fire ? HRDATA : '0;
   assign rdata_valid = rd_fire;
   assign rdata_last  = rd_fire && dp_last_reg;
   assign done        = done_reg;
   assign err         = err_reg;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg    <= IDLE;
         haddr_reg    <= '0;
         htrans_reg   <= HT_IDLE;
         hwrite_reg   <= 1'b0;
         hsize_reg    <= 3'd0;
         hburst_reg   <= 3'd0;
         hwdata_reg   <= '0;
         beat_reg     <= 4'd0;
         last_reg     <= 4'd0;
         wrap_reg     <= 1'b0;
         dp_valid_reg <= 1'b0;
         dp_write_reg <= 1'b0;
         dp_last_reg  <= 1'b0;
         stg_full_reg <= 1'b0;
         stg_data_reg <= '0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         stg_full_reg <= stg_full_next;
         if (accept_w)
            stg_data_reg <= wdata;
         if (HREADY) begin
            dp_valid_reg <= addr_done;
            if (addr_done) begin
               dp_write_reg <= hwrite_reg;
               dp_last_reg  <= (beat_reg == last_reg);
               if (hwrite_reg)
                  hwdata_reg <= stg_data_reg;
            end
         end
         // First ERROR cycle: cancel the pending address phase and drop staged data
         if (dp_err && state_reg != ERR) begin
            state_reg    <= ERR;
            err_reg      <= 1'b1;
            htrans_reg   <= HT_IDLE;
            stg_full_reg <= 1'b0;
            dp_valid_reg <= !HREADY;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (cmd_valid) begin
                     if (cmd_size > MAX_SIZE) begin
                        state_reg    <= ERR;
                        err_reg      <= 1'b1;
                        stg_full_reg <= 1'b0;
                     end else begin
                        state_reg  <= NSEQ;
                        haddr_reg  <= cmd_addr;
                        hwrite_reg <= cmd_write;
                        hsize_reg  <= cmd_size;
                        hburst_reg <= cmd_hburst;
                        last_reg   <= cmd_last;
                        wrap_reg   <= cmd_wrap;
                        beat_reg   <= 4'd0;
                        htrans_reg <= (!cmd_write || stg_full_next) ? HT_NONSEQ : HT_IDLE;
                     end
                  end
               end
               NSEQ, SEQ: begin
                  if (HREADY) begin
                     if (addr_done) begin
                        if (beat_reg == last_reg) begin
                           htrans_reg <= HT_IDLE;
                           state_reg  <= LAST_DATA;
                        end else begin
                           haddr_reg  <= next_addr;
                           beat_reg   <= beat_reg + 4'd1;
                           state_reg  <= SEQ;
                           htrans_reg <= (!hwrite_reg || stg_full_next) ? HT_SEQ : HT_BUSY;
                        end
                     end else if (!hwrite_reg || stg_full_next) begin
                        htrans_reg <= (state_reg == NSEQ) ? HT_NONSEQ : HT_SEQ;
                     end
                  end
               end
               LAST_DATA: begin
                  if (HREADY) begin
                     done_reg  <= dp_valid_reg && dp_last_reg;
                     state_reg <= IDLE;
                  end
               end
               ERR: begin
                  if (HREADY || !dp_valid_reg)
                     state_reg <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Directed bench for ahb_lite_burst_master: bench-side AHB slave, write-data source and hand-computed expectations.
module tb_ahb_lite_burst_master;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic [AW-1:0] HADDR;
   logic          HWRITE;
   logic [2:0]    HSIZE, HBURST;
   logic [3:0]    HPROT;
   logic [1:0]    HTRANS;
   logic          HMASTLOCK;
   logic [DW-1:0] HWDATA, HRDATA;
   logic          HREADY, HRESP;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [2:0]    cmd_size, cmd_burst;
   logic          wdata_valid, wdata_ready;
   logic [DW-1:0] wdata, rdata;
   logic          rdata_valid, rdata_last, done, err;

   ahb_lite_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .rdata(rdata),
      .rdata_valid(rdata_valid), .rdata_last(rdata_last), .done(done), .err(err)
   );

   always #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_bad = 0;
   int gap_after, gap_len, stall_beat, stall_len, err_beat;
   int n_addr, n_busy, n_rd, n_done, n_err, done_cyc, err_cyc, last_dp_cyc, first_ns_cyc;
   logic [31:0] addr_log [32];
   logic [1:0]  trans_log [32];
   logic [31:0] exp_addr [16];
   logic [31:0] busy_addr;
   logic [2:0]  burst_seen;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wpat(input int k);
      return 32'hC0DE_0000 + 32'(k);
   endfunction

   function automatic logic [31:0] rpat(input int k);
      return 32'h5EED_0100 + 32'(k);
   endfunction

   task automatic chk_addrs(input string name, input int n);
      chk({name, ":beats"}, 64'(n_addr), 64'(n));
      for (int i = 0; i < n && i < n_addr; i++) begin
         chk($sformatf("%s:haddr%0d", name, i), addr_log[i], exp_addr[i]);
         chk($sformatf("%s:htrans%0d", name, i), trans_log[i], (i == 0) ? 2'b10 : 2'b11);
      end
   endtask

   // Issues one command, plays slave/write-source each cycle, samples on the falling edge.
   task automatic run_cmd(input string name, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [2:0] burst, input int nbeats);
      int cyc = 0, words = 0, gap_left = 0, stall_cnt = 0, err_step = 0, tail = -1, pend_beat = 0;
      bit gap_done = 0, pend = 0, stall_now, exp_rv;
      logic [31:0] snap_addr, snap_wdata;
      logic [1:0]  snap_trans;
      n_addr = 0; n_busy = 0; n_rd = 0; n_done = 0; n_err = 0;
      done_cyc = -1; err_cyc = -1; last_dp_cyc = -1; first_ns_cyc = -1;
      busy_addr = '0; burst_seen = 3'bxxx;
      snap_addr = '0; snap_wdata = '0; snap_trans = '0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_burst = burst;
      while (tail != 0 && cyc < 200) begin
         if (gap_after >= 0 && words == gap_after && !gap_done) begin
            gap_left = gap_len;
            gap_done = 1;
         end
         wdata_valid = wr && gap_left == 0 && words < nbeats;
         wdata = wpat(words);
         if (gap_left > 0) gap_left--;
         HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; stall_now = 0;
         if (pend) begin
            if (!wr) HRDATA = rpat(pend_beat);
            if (pend_beat == stall_beat && stall_cnt < stall_len) begin
               HREADY = 1'b0;
               stall_now = 1;
            end
            if (pend_beat == err_beat) begin
               HRESP = 1'b1;
               HREADY = (err_step != 0);
            end
         end
         @(negedge HCLK);
         if (cyc == 0) chk({name, ":cmd_ready"}, cmd_ready, 1);
         if (done) begin n_done++; done_cyc = cyc; end
         if (err) begin n_err++; err_cyc = cyc; end
         if (stall_now) begin
            if (stall_cnt == 0) begin
               snap_addr = HADDR; snap_trans = HTRANS; snap_wdata = HWDATA;
            end else begin
               chk({name, ":stall_haddr"}, HADDR, snap_addr);
               chk({name, ":stall_htrans"}, HTRANS, snap_trans);
               chk({name, ":stall_hwdata"}, HWDATA, snap_wdata);
            end
            stall_cnt++;
         end
         if (pend && pend_beat == err_beat) begin
            if (err_step == 1) chk({name, ":htrans_err2"}, HTRANS, 2'b00);
            err_step++;
         end
         exp_rv = pend && !wr && HREADY && !HRESP;
         if (exp_rv || rdata_valid) begin
            chk({name, ":rdata_valid"}, rdata_valid, exp_rv);
            if (exp_rv) begin
               chk($sformatf("%s:rdata%0d", name, pend_beat), rdata, rpat(pend_beat));
               chk($sformatf("%s:rlast%0d", name, pend_beat), rdata_last, pend_beat == nbeats - 1);
               n_rd++;
            end
         end
         if (pend && wr && HREADY && !HRESP)
            chk($sformatf("%s:hwdata%0d", name, pend_beat), HWDATA, wpat(pend_beat));
         if (pend && HREADY && !HRESP && pend_beat == nbeats - 1) last_dp_cyc = cyc;
         if (HTRANS == 2'b01) begin n_busy++; busy_addr = HADDR; end
         if (HREADY && HTRANS[1]) begin
            if (HTRANS == 2'b10) begin first_ns_cyc = cyc; burst_seen = HBURST; end
            if (n_addr < 32) begin addr_log[n_addr] = HADDR; trans_log[n_addr] = HTRANS; end
            pend = 1; pend_beat = n_addr; n_addr++;
         end else if (HREADY) begin
            pend = 0;
         end
         if (wdata_valid && wdata_ready) words++;
         if (tail > 0) tail--;
         else if (tail < 0 && (done || err)) tail = 2;
         @(posedge HCLK); #1;
         cmd_valid = 1'b0;
         cyc++;
      end
      wdata_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      chk({name, ":finished_in_budget"}, tail == 0, 1);
      $display("txn %s wr=%0d addr=0x%08h burst=%03b beats=%0d busy=%0d rd=%0d done=%0d err=%0d",
               name, wr, addr, burst, n_addr, n_busy, n_rd, n_done, n_err);
   endtask

   initial begin
      bit seen_pulse;
      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_burst = '0;
      wdata_valid = 1'b0; wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
      gap_after = -1; gap_len = 0; stall_beat = -1; stall_len = 0; err_beat = -1;
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_haddr", HADDR, 0);
      chk("rst_hprot", HPROT, 4'b0011);
      chk("rst_hmastlock", HMASTLOCK, 0);
      chk("rst_done_err", {done, err, rdata_valid}, 3'b000);
      @(negedge HCLK); HRESETn = 1'b1;
      @(posedge HCLK); #1;
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // Write INCR4 at 0x100, data always available
      run_cmd("wr_incr4", 1'b1, 32'h100, 3'd2, 3'b011, 4);
      exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108; exp_addr[3] = 32'h10C;
      chk_addrs("wr_incr4", 4);
      chk("wr_incr4:hburst", burst_seen, 3'b011);
      chk("wr_incr4:first_nonseq_cyc", first_ns_cyc, 1);
      chk("wr_incr4:done_cnt", n_done, 1);
      chk("wr_incr4:done_cyc", done_cyc, 6);
      chk("wr_incr4:err_cnt", n_err, 0);

      // Read WRAP4 at 0x38
      run_cmd("rd_wrap4", 1'b0, 32'h38, 3'd2, 3'b010, 4);
`ifdef AHBM_WRAP_EN
      exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h30; exp_addr[3] = 32'h34;
      chk("rd_wrap4:hburst", burst_seen, 3'b010);
`else
      exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h40; exp_addr[3] = 32'h44;
      chk("rd_wrap4:hburst", burst_seen, 3'b011);
`endif
      chk_addrs("rd_wrap4", 4);
      chk("rd_wrap4:rd_cnt", n_rd, 4);
      chk("rd_wrap4:done_cnt", n_done, 1);

      // Write INCR8 with a 2-cycle write-data gap after the third word
      gap_after = 3; gap_len = 2;
      run_cmd("wr_incr8_gap", 1'b1, 32'h200, 3'd2, 3'b101, 8);
      gap_after = -1; gap_len = 0;
      for (int i = 0; i < 8; i++) exp_addr[i] = 32'h200 + 32'(4 * i);
      chk_addrs("wr_incr8_gap", 8);
      chk("wr_incr8_gap:busy_cycles", n_busy, 2);
      chk("wr_incr8_gap:busy_haddr", busy_addr, 32'h20C);
      chk("wr_incr8_gap:done_cnt", n_done, 1);

      // Read INCR16 with a two-cycle ERROR response on the fifth beat
      err_beat = 4;
      run_cmd("rd_incr16_err", 1'b0, 32'h400, 3'd2, 3'b111, 16);
      err_beat = -1;
      chk("rd_incr16_err:err_cnt", n_err, 1);
      chk("rd_incr16_err:done_cnt", n_done, 0);
      chk("rd_incr16_err:rd_cnt", n_rd, 4);
      chk("rd_incr16_err:addr_phases", n_addr, 5);
      chk("rd_incr16_err:cmd_ready_after", cmd_ready, 1);

      // Write INCR4 with 3 wait states on the second data phase
      stall_beat = 1; stall_len = 3;
      run_cmd("wr_incr4_stall", 1'b1, 32'h600, 3'd2, 3'b011, 4);
      stall_beat = -1; stall_len = 0;
      exp_addr[0] = 32'h600; exp_addr[1] = 32'h604; exp_addr[2] = 32'h608; exp_addr[3] = 32'h60C;
      chk_addrs("wr_incr4_stall", 4);
      chk("wr_incr4_stall:done_cyc", done_cyc, 9);

      // Oversized transfer: accepted, err next cycle, no bus traffic
      run_cmd("rd_bad_size", 1'b0, 32'h700, 3'd3, 3'b000, 1);
      chk("rd_bad_size:err_cnt", n_err, 1);
      chk("rd_bad_size:err_cyc", err_cyc, 1);
      chk("rd_bad_size:addr_phases", n_addr, 0);
      chk("rd_bad_size:done_cnt", n_done, 0);

      // INCR runs as a SINGLE
      run_cmd("rd_incr", 1'b0, 32'h804, 3'd2, 3'b001, 1);
      chk("rd_incr:hburst", burst_seen, 3'b000);
      chk("rd_incr:addr_phases", n_addr, 1);
      chk("rd_incr:rd_cnt", n_rd, 1);
      chk("rd_incr:done_cnt", n_done, 1);

      // Write SINGLE whose data arrives two cycles after the command
      gap_after = 0; gap_len = 2;
      run_cmd("wr_single_late", 1'b1, 32'h900, 3'd2, 3'b000, 1);
      gap_after = -1; gap_len = 0;
      chk("wr_single_late:first_nonseq_cyc", first_ns_cyc, 3);
      chk("wr_single_late:addr_phases", n_addr, 1);
      chk("wr_single_late:done_cnt", n_done, 1);

      // Asynchronous reset in the middle of a write INCR8
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hA00; cmd_size = 3'd2; cmd_burst = 3'b101;
      wdata_valid = 1'b1; wdata = 32'hA5A5_0001; HRDATA = 32'hFFFF_FFFF;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      repeat (2) begin @(posedge HCLK); #1; end
      chk("mid_rst:pre_htrans", HTRANS, 2'b11);
      HRESETn = 1'b0;
      #1;
      chk("mid_rst:htrans", HTRANS, 2'b00);
      chk("mid_rst:haddr", HADDR, 0);
      chk("mid_rst:hwrite", HWRITE, 0);
      chk("mid_rst:hsize", HSIZE, 0);
      chk("mid_rst:hburst", HBURST, 0);
      chk("mid_rst:hwdata", HWDATA, 0);
      chk("mid_rst:hprot", HPROT, 4'b0011);
      chk("mid_rst:hmastlock", HMASTLOCK, 0);
      chk("mid_rst:rdata", rdata, 0);
      chk("mid_rst:status", {rdata_valid, rdata_last, done, err}, 4'b0000);
      wdata_valid = 1'b0;
      @(negedge HCLK); HRESETn = 1'b1;
      seen_pulse = 0;
      repeat (4) begin
         @(negedge HCLK);
         if (done || err) seen_pulse = 1;
      end
      chk("mid_rst:no_done_err", seen_pulse, 0);
      chk("mid_rst:cmd_ready", cmd_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
